// File: rtl/oled_fb_pkg.sv
// Shared definitions for the OLED frame buffer: geometry, RGB565 colour
// type, named colours and the sweep FSM state encoding.
package oled_fb_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t BLACK = 16'h0000;
  localparam rgb565_t WHITE = 16'hFFFF;
  localparam rgb565_t RED   = 16'hF800;
  localparam rgb565_t GREEN = 16'h07E0;
  localparam rgb565_t BLUE  = 16'h001F;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

endpackage

// File: rtl/oled_fb_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// No reset on the array so it maps onto block RAM.
module oled_fb_ram
  import oled_fb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = OLED_PIXELS,
  parameter int ADDR_W = 13
) (
  input  logic              clock_100mhz,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store one word on each enabled edge
  always_ff @(posedge clock_100mhz) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: synchronous read, data valid one edge after the address
  always_ff @(posedge clock_100mhz) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/oled_frame_buffer.sv
// 96x64 RGB565 frame buffer between student drawing logic and the OLED
// data mux. Writes use a valid/ready handshake; a sweep FSM fills the
// buffer with one colour after reset and on clear_req. Reads have a fixed
// two-cycle latency (RAM read, then output register).
// Optional double buffering is enabled by defining OLED_FB_DOUBLE_BUFFER_EN:
// writes and clears then go to the back bank, reads come from the front
// bank, and swap_req exchanges the banks on the next frame_begin.
module oled_frame_buffer
  import oled_fb_pkg::*;
#(
  parameter int      WIDTH        = OLED_WIDTH,
  parameter int      HEIGHT       = OLED_HEIGHT,
  parameter rgb565_t RESET_COLOUR = BLACK
) (
  input  logic        clock_100mhz,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_x,
  input  logic [5:0]  wr_y,
  input  logic [15:0] wr_colour,
  output logic        wr_err,
  input  logic        clear_req,
  input  logic [15:0] clear_colour,
  output logic        busy,
  input  logic        frame_begin,
`ifdef OLED_FB_DOUBLE_BUFFER_EN
  input  logic        swap_req,
`endif
  input  logic [12:0] pixel_index,
  output logic [15:0] oled_data
);

  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int ADDR_W = 13;
`ifdef OLED_FB_DOUBLE_BUFFER_EN
  // Reset sweep covers both banks back to back, so one extra counter bit
  localparam int CNT_W = ADDR_W + 1;
`else
  localparam int CNT_W = ADDR_W;
`endif
  localparam logic [CNT_W-1:0] LAST_ONE = CNT_W'(PIXELS - 1);

  fb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rgb565_t          fill_q, fill_d;

  logic              wr_accept;
  logic              wr_in_range;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] sweep_addr;
  logic [ADDR_W-1:0] ram_waddr;
  rgb565_t           ram_wdata;
  logic              ram_we;
  logic [CNT_W-1:0]  sweep_last;

  logic    oob_p0;
  rgb565_t frame_data_p0;

`ifdef OLED_FB_DOUBLE_BUFFER_EN
  logic    clear_all_q, clear_all_d;
  logic    front_q;
  logic    swap_pend_q;
  logic    front_p0;
  logic    sweep_hi;
  logic    wr_bank;
  rgb565_t rdata0_p0, rdata1_p0;
  localparam logic [CNT_W-1:0] LAST_TWO = CNT_W'(2 * PIXELS - 1);
`else
  rgb565_t rdata_p0;
  logic    unused_frame_begin;
  assign unused_frame_begin = frame_begin;
`endif

  // Write address and range check for the handshake port
  assign wr_accept   = wr_valid && wr_ready;
  assign wr_in_range = (wr_x < 7'(WIDTH)) && ({1'b0, wr_y} < 7'(HEIGHT));
  assign wr_addr     = ({7'd0, wr_y} * 13'(WIDTH)) + {6'd0, wr_x};

  // State, sweep counter and fill colour registers
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      fill_q      <= RESET_COLOUR;
`ifdef OLED_FB_DOUBLE_BUFFER_EN
      clear_all_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
`ifdef OLED_FB_DOUBLE_BUFFER_EN
      clear_all_q <= clear_all_d;
`endif
    end
  end

`ifdef OLED_FB_DOUBLE_BUFFER_EN
  assign sweep_last = clear_all_q ? LAST_TWO : LAST_ONE;
`else
  assign sweep_last = LAST_ONE;
`endif

  // Next-state logic: IDLE accepts writes and clear requests, CLEAR sweeps
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    wr_ready = 1'b0;
    busy     = 1'b0;
`ifdef OLED_FB_DOUBLE_BUFFER_EN
    clear_all_d = clear_all_q;
`endif
    case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          fill_d  = clear_colour;
`ifdef OLED_FB_DOUBLE_BUFFER_EN
          clear_all_d = 1'b0;
`endif
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (cnt_q == sweep_last) begin
          state_d = IDLE;
          cnt_d   = '0;
`ifdef OLED_FB_DOUBLE_BUFFER_EN
          clear_all_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef OLED_FB_DOUBLE_BUFFER_EN
  // Second half of the reset sweep wraps the address back into the bank
  assign sweep_hi   = clear_all_q && (cnt_q >= CNT_W'(PIXELS));
  assign sweep_addr = sweep_hi ? (cnt_q[ADDR_W-1:0] - ADDR_W'(PIXELS))
                               : cnt_q[ADDR_W-1:0];
  assign wr_bank    = (busy && clear_all_q) ? sweep_hi : ~front_q;
`else
  assign sweep_addr = cnt_q;
`endif

  // The sweep owns the write port while busy; out-of-range writes are dropped
  assign ram_waddr = busy ? sweep_addr : wr_addr;
  assign ram_wdata = busy ? fill_q : wr_colour;
  assign ram_we    = busy || (wr_accept && wr_in_range);

  // Error pulse for an accepted out-of-range write
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_accept && !wr_in_range;
    end
  end

`ifdef OLED_FB_DOUBLE_BUFFER_EN
  // Bank swap: pending request taken on the first frame_begin while idle
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      front_q     <= 1'b0;
      swap_pend_q <= 1'b0;
    end else if (frame_begin && (swap_pend_q || swap_req) && !busy) begin
      front_q     <= ~front_q;
      swap_pend_q <= 1'b0;
    end else if (swap_req) begin
      swap_pend_q <= 1'b1;
    end
  end

  oled_fb_ram #(.DATA_W(16), .DEPTH(PIXELS), .ADDR_W(ADDR_W)) u_ram_bank0 (
    .clock_100mhz (clock_100mhz),
    .we           (ram_we && !wr_bank),
    .waddr        (ram_waddr),
    .wdata        (ram_wdata),
    .raddr        (pixel_index),
    .rdata        (rdata0_p0)
  );

  oled_fb_ram #(.DATA_W(16), .DEPTH(PIXELS), .ADDR_W(ADDR_W)) u_ram_bank1 (
    .clock_100mhz (clock_100mhz),
    .we           (ram_we && wr_bank),
    .waddr        (ram_waddr),
    .wdata        (ram_wdata),
    .raddr        (pixel_index),
    .rdata        (rdata1_p0)
  );

  assign frame_data_p0 = front_p0 ? rdata1_p0 : rdata0_p0;
`else
  oled_fb_ram #(.DATA_W(16), .DEPTH(PIXELS), .ADDR_W(ADDR_W)) u_ram (
    .clock_100mhz (clock_100mhz),
    .we           (ram_we),
    .waddr        (ram_waddr),
    .wdata        (ram_wdata),
    .raddr        (pixel_index),
    .rdata        (rdata_p0)
  );

  assign frame_data_p0 = rdata_p0;
`endif

  // Stage p0: range flag (and front bank) travel alongside the RAM read
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      oob_p0   <= 1'b1;
`ifdef OLED_FB_DOUBLE_BUFFER_EN
      front_p0 <= 1'b0;
`endif
    end else begin
      oob_p0   <= (pixel_index >= 13'(PIXELS));
`ifdef OLED_FB_DOUBLE_BUFFER_EN
      front_p0 <= front_q;
`endif
    end
  end

  // Stage p1: output register, out-of-range reads return black
  always_ff @(posedge clock_100mhz or posedge reset) begin
    if (reset) begin
      oled_data <= BLACK;
    end else begin
      oled_data <= oob_p0 ? BLACK : frame_data_p0;
    end
  end

endmodule

// File: tb/tb_oled_frame_buffer.sv
// Self-checking bench for oled_frame_buffer: directed steps plus random
// writes/reads compared against a pixel-array model of the buffer.
module tb_oled_frame_buffer;

  localparam int W = 96;
  localparam int H = 64;
  localparam int N = W * H;
`ifdef OLED_FB_DOUBLE_BUFFER_EN
  localparam int DB = 1;
`else
  localparam int DB = 0;
`endif
  localparam int RESET_SWEEP = (DB != 0) ? 2 * N : N;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [6:0]  wr_x;
  logic [5:0]  wr_y;
  logic [15:0] wr_colour;
  logic        wr_err;
  logic        clear_req;
  logic [15:0] clear_colour;
  logic        busy;
  logic        frame_begin;
  logic        swap_req;
  logic [12:0] pixel_index;
  logic [15:0] oled_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_mem [2][N];
  int          front = 0;
  int          written[$];

  always #5 clk = ~clk;

  oled_frame_buffer dut (
    .clock_100mhz (clk),
    .reset        (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_colour    (wr_colour),
    .wr_err       (wr_err),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .busy         (busy),
    .frame_begin  (frame_begin),
`ifdef OLED_FB_DOUBLE_BUFFER_EN
    .swap_req     (swap_req),
`endif
    .pixel_index  (pixel_index),
    .oled_data    (oled_data)
  );

  function automatic int back_bank();
    return (DB != 0) ? 1 - front : front;
  endfunction

  function automatic logic [15:0] expect_pix(input int idx);
    return (idx >= N) ? 16'h0000 : model_mem[front][idx];
  endfunction

  task automatic model_fill(input int bank, input logic [15:0] c);
    for (int i = 0; i < N; i++) model_mem[bank][i] = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic read_one(input int idx, input string tag);
    pixel_index = 13'(idx);
    tick();
    tick();
    check(tag, {16'd0, oled_data}, {16'd0, expect_pix(idx)});
  endtask

  // Pipelined full scan: one address per cycle, output lags by two edges
  task automatic scan_all(input string tag);
    int bad = 0;
    for (int i = 0; i <= N; i++) begin
      pixel_index = (i < N) ? 13'(i) : 13'd0;
      tick();
      if (i >= 1 && oled_data !== expect_pix(i - 1)) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic do_write(input int x, input int y, input logic [15:0] c, input string tag);
    logic oob;
    oob = (x >= W) || (y >= H);
    check({tag, "_ready"}, {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1; wr_x = 7'(x); wr_y = 6'(y); wr_colour = c;
    tick();
    wr_valid = 1'b0;
    if (!oob) begin
      model_mem[back_bank()][y * W + x] = c;
      written.push_back(y * W + x);
    end
    check({tag, "_err"}, {31'd0, wr_err}, {31'd0, oob});
  endtask

  // Counts cycles busy stays high; optionally fires a clear_req mid-sweep
  task automatic wait_busy(input int exp_len, input int inject_at, input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 20000) begin
      if (n == inject_at) begin
        clear_req = 1'b1;
        clear_colour = 16'h1234;
      end
      tick();
      n++;
      clear_req = 1'b0;
    end
    check(tag, n, exp_len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_colour = '0;
    clear_req = 1'b0; clear_colour = '0; frame_begin = 1'b0; swap_req = 1'b0;
    pixel_index = '0;

    // Reset state
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_wr_err", {31'd0, wr_err}, 32'd0);
    check("rst_oled_data", {16'd0, oled_data}, 32'd0);
    model_fill(0, 16'h0000);
    model_fill(1, 16'h0000);
    front = 0;

    // Reset sweep length and contents
    rst = 1'b0;
    wait_busy(RESET_SWEEP, -1, "reset_sweep_len");
    check("idle_wr_ready", {31'd0, wr_ready}, 32'd1);
    scan_all("reset_scan");

    // Directed write and neighbour
    do_write(5, 2, 16'hF800, "wr_5_2");
    read_one(197, "rd_197");
    read_one(196, "rd_196");

    // Out-of-range column
    do_write(96, 0, 16'hFFFF, "wr_96_0");
    tick();
    check("wr_err_one_cycle", {31'd0, wr_err}, 32'd0);
    read_one(96, "rd_96");

    // Random writes including out-of-range columns
    for (int k = 0; k < 40; k++) begin
      do_write($urandom_range(0, 110), $urandom_range(0, 63), 16'($urandom), "rand_wr");
    end
    for (int k = 0; k < 40; k++) begin
      int idx;
      if (k % 3 == 2) idx = $urandom_range(0, 8191);
      else idx = written[$urandom_range(0, written.size() - 1)];
      read_one(idx, "rand_rd");
    end
    read_one(7000, "rd_7000_a");

`ifdef OLED_FB_DOUBLE_BUFFER_EN
    // Back-bank write is invisible until a swap on frame_begin
    do_write(1, 1, 16'hFFFF, "db_wr_1_1");
    read_one(97, "db_rd_97_before");
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    front = 1 - front;
    read_one(97, "db_rd_97_after");
`endif

    // Clear and write in the same cycle; the clear overwrites the pixel
    wr_valid = 1'b1; wr_x = 7'd0; wr_y = 6'd0; wr_colour = 16'h001F;
    clear_req = 1'b1; clear_colour = 16'h07E0;
    tick();
    wr_valid = 1'b0; clear_req = 1'b0;
    model_mem[back_bank()][0] = 16'h001F;
    check("clr_wr_ready_drop", {31'd0, wr_ready}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd1);
    model_fill(back_bank(), 16'h07E0);
    wait_busy(N, 100, "clear_sweep_len");
    read_one(0, "clr_rd_0");
    for (int k = 0; k < 8; k++) read_one($urandom_range(0, N - 1), "clr_rd_rand");

    // Reset in the middle of a sweep
    clear_req = 1'b1; clear_colour = 16'hFFFF;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 3000; k++) tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd1);
    check("midrst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("midrst_oled_data", {16'd0, oled_data}, 32'd0);
    model_fill(0, 16'h0000);
    model_fill(1, 16'h0000);
    front = 0;
    tick();
    tick();
    rst = 1'b0;
    wait_busy(RESET_SWEEP, -1, "midrst_sweep_len");
    read_one(6143, "rd_6143");
    read_one(7000, "rd_7000_b");
    scan_all("midrst_scan");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
